// File: rtl/div_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : div_pkg
// Brief   : Shared FSM encoding and counter sizing for the sequential divider.
// Revision: 1.0
// ============================================================================
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIV_WIDTH = 16;
    localparam int CNT_W     = $clog2(DIV_WIDTH);

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : div_step
// Brief   : One combinational restoring-division step (shift in a bit, trial subtract).
// Revision: 1.0
// ============================================================================
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] w_trial;

    // rem < divisor on entry, so a successful subtract always fits in WIDTH bits.
    always_comb begin
        w_trial  = {rem, bit_in};
        q_bit    = (w_trial >= {1'b0, divisor});
        rem_next = q_bit ? (w_trial[WIDTH-1:0] - divisor) : w_trial[WIDTH-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/seq_divider_unsigned.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : seq_divider_unsigned
// Brief   : Multi-cycle 2W/W unsigned restoring divider with valid/ready handshakes.
// Revision: 1.0
// ============================================================================
module seq_divider_unsigned
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero,
    output logic                 overflow,
    output logic                 busy
);

    localparam int                 C_CNT_W    = cnt_width(WIDTH);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_low;
    logic [WIDTH-1:0]   r_divisor;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_dbz;
    logic               r_ovf;

    logic [WIDTH-1:0]   w_rem_next;
    logic               w_q_bit;
    logic               w_accept;
    logic               w_dbz_in;
    logic               w_ovf_in;
    logic               w_last;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_dbz_in = (divisor == '0);
    assign w_ovf_in = !w_dbz_in && (dividend[2*WIDTH-1:WIDTH] >= divisor);
    assign w_last   = (r_cnt == '0);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (r_rem),
        .bit_in   (r_low[WIDTH-1]),
        .divisor  (r_divisor),
        .rem_next (w_rem_next),
        .q_bit    (w_q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_dbz_in || w_ovf_in) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (r_state == IDLE);
        busy        = (r_state == BUSY);
        out_valid   = (r_state == DONE);
        quotient    = r_low;
        remainder   = r_rem;
        div_by_zero = r_dbz;
        overflow    = r_ovf;
    end

    // r_low starts as the low dividend half and is gradually replaced by quotient bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem     <= '0;
            r_low     <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_dbz     <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (w_accept) begin
            r_divisor <= divisor;
            r_dbz     <= w_dbz_in;
            r_ovf     <= w_ovf_in;
            r_cnt     <= C_CNT_LAST;
            if (w_dbz_in || w_ovf_in) begin
                r_rem <= dividend[WIDTH-1:0];
                r_low <= '1;
            end else begin
                r_rem <= dividend[2*WIDTH-1:WIDTH];
                r_low <= dividend[WIDTH-1:0];
            end
        end else if (r_state == BUSY) begin
            r_rem <= w_rem_next;
            r_low <= {r_low[WIDTH-2:0], w_q_bit};
            if (!w_last) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider_unsigned.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_seq_divider_unsigned
// Brief   : Directed and randomized self-checking bench for seq_divider_unsigned.
// Revision: 1.0
// ============================================================================
module tb_seq_divider_unsigned;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;
    logic        busy;

    int errors = 0;
    int checks = 0;

    seq_divider_unsigned #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one operation, waits for out_valid and returns the latency in edges.
    task automatic start_op(input logic [31:0] dvd, input logic [15:0] dvs, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        dividend = dvd;
        divisor  = dvs;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] dvd;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_results", {quotient, remainder}, 32'd0);
        chk("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 100 / 7
        start_op(32'h0000_0064, 16'd7, lat);
        chk("t1_latency", lat, 32'd17);
        chk("t1_result", {quotient, remainder}, {16'd14, 16'd2});
        chk("t1_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        ack();
        chk("t1_idle_after_ack", {30'd0, out_valid, in_ready}, 32'd1);

        // Largest in-range quotient
        start_op(32'hFFFE_0001, 16'hFFFF, lat);
        chk("t2a_result", {quotient, remainder}, {16'hFFFF, 16'h0000});
        chk("t2a_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        ack();

        // Overflow boundary: high half equals divisor
        start_op(32'h0001_0000, 16'd1, lat);
        chk("t2b_latency", lat, 32'd1);
        chk("t2b_result", {quotient, remainder}, {16'hFFFF, 16'h0000});
        chk("t2b_flags", {30'd0, div_by_zero, overflow}, 32'd1);
        ack();

        // Divide by zero
        start_op(32'h1234_5678, 16'd0, lat);
        chk("t3_latency", lat, 32'd1);
        chk("t3_result", {quotient, remainder}, {16'hFFFF, 16'h5678});
        chk("t3_flags", {30'd0, div_by_zero, overflow}, 32'd2);
        ack();

        // Backpressure with a competing request
        start_op(32'd1000, 16'd10, lat);
        chk("t4_flags_cleared", {30'd0, div_by_zero, overflow}, 32'd0);
        dividend = 32'h0000_0064;
        divisor  = 16'd7;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t4_hold_valid", {30'd0, out_valid, in_ready}, 32'd2);
            chk("t4_hold_result", {quotient, remainder}, {16'd100, 16'd0});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("t4_idle_gap", {29'd0, out_valid, in_ready, busy}, 32'd2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t4_accepted", {29'd0, out_valid, in_ready, busy}, 32'd1);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("t4_latency", lat, 32'd17);
        chk("t4_result", {quotient, remainder}, {16'd14, 16'd2});
        ack();

        // Asynchronous reset during iteration
        dividend = 32'h00FF_ABCD;
        divisor  = 16'h1234;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_ctrl", {29'd0, out_valid, in_ready, busy}, 32'd2);
        chk("t5_async_results", {quotient, remainder}, 32'd0);
        chk("t5_async_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t5_after_release", {29'd0, out_valid, in_ready, busy}, 32'd2);
        start_op(32'h0000_0064, 16'd7, lat);
        chk("t5_redo_latency", lat, 32'd17);
        chk("t5_redo_result", {quotient, remainder}, {16'd14, 16'd2});
        ack();

        // Round trip: (a*b)/b
        for (int i = 0; i < 1000; i++) begin
            a   = 16'($urandom_range(0, 65535));
            b   = 16'($urandom_range(1, 65535));
            dvd = 32'(a) * 32'(b);
            start_op(dvd, b, lat);
            chk("t6_roundtrip", {quotient, remainder}, {a, 16'd0});
            ack();
        end

        // Random in-range dividends against a reference division
        for (int i = 0; i < 200; i++) begin
            b   = 16'($urandom_range(1, 65535));
            dvd = {16'($urandom_range(0, 32'(b) - 1)), 16'($urandom_range(0, 65535))};
            start_op(dvd, b, lat);
            chk("t6_reference", {quotient, remainder}, {16'(dvd / 32'(b)), 16'(dvd % 32'(b))});
            chk("t6_ref_flags", {30'd0, div_by_zero, overflow}, 32'd0);
            ack();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
